hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  in  1  pipeline clock; all state updates on posedge.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 MemRead_ex  in  1  load instruction in EX.
REQ-005 rdAddr_ex  in  5  destination register of the EX instruction.
REQ-006 rs1Addr_id, rs2Addr_id  in  5 each  source registers of the ID instruction.
REQ-007 rs1Used_id, rs2Used_id  in  1 each  ID instruction reads rs1 / rs2.
REQ-008 Redirect_ex  in  1  branch taken or jump resolved in EX.
REQ-009 dmem_req  in  1  MEM-stage access in progress (MemRead_mem or MemWrite_mem).
REQ-010 dmem_ready  in  1  data memory completes the MEM access this cycle.
REQ-011 PC_stall, IFID_stall, IDEX_stall, EXMEM_stall  out  1 each  hold the corresponding register.
REQ-012 IFID_flush, IDEX_flush  out  1 each  clear the register; IDEX_flush drives the ID/EX clear input R.
REQ-013 mem_timeout  out  1  sticky error flag.
REQ-014 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-015 The FSM SHALL have three states, RUN, MEM_WAIT and REDIR_PEND, encoded in 2 bits.
REQ-016 Load-use hazard: MemRead_ex=1, rdAddr_ex!=0, and rdAddr_ex matches rs1Addr_id with rs1Used_id=1 or rs2Addr_id with rs2Used_id=1.
REQ-017 Memory wait: dmem_req=1 and dmem_ready=0.
REQ-018 All hazard outputs SHALL be combinational from the current state and inputs, so they apply in the same cycle.
REQ-019 Memory-wait response (highest priority): assert all four stall outputs; deassert both flushes.
REQ-020 Redirect response, RUN state only, no memory wait, Redirect_ex=1: assert IFID_flush and IDEX_flush; assert no stall.
REQ-021 Load-use response, no memory wait, no redirect: assert PC_stall, IFID_stall and IDEX_flush.
REQ-022 Load-use stall length SHALL be exactly one cycle, since the load advances to MEM.
REQ-023 RUN->MEM_WAIT: on a memory wait; a simultaneous Redirect_ex=1 SHALL be recorded in a pend flag.
REQ-024 MEM_WAIT->RUN: when dmem_ready=1 or dmem_req=0, with no pend flag.
REQ-025 MEM_WAIT->REDIR_PEND: on the same exit condition, when the pend flag is set.
REQ-026 A Redirect_ex=1 arriving during MEM_WAIT SHALL also set the pend flag.
REQ-027 REDIR_PEND: assert IFID_flush and IDEX_flush for exactly one cycle; clear the pend flag; go to RUN.
REQ-028 REDIR_PEND SHALL ignore load-use hazards and Redirect_ex.
REQ-029 Wait counter: 8 bits, cleared on entering MEM_WAIT, incremented each MEM_WAIT cycle.
REQ-030 When the wait counter reaches 255, mem_timeout SHALL set and stay set until reset.
REQ-031 Wait-counter timeout SHALL NOT release the stall; the FSM stays in MEM_WAIT.
REQ-032 stall_cnt SHALL increment on every cycle PC_stall=1 and saturate at 0xFFFF.
REQ-033 flush_cnt SHALL increment on every cycle IDEX_flush=1 and saturate at 0xFFFF.
REQ-034 rdAddr_ex=0 SHALL never cause a load-use stall.

Reset
REQ-035 When rst_n=0 at posedge clk: state=RUN; pend flag, wait counter, mem_timeout, stall_cnt and flush_cnt SHALL all be 0.
REQ-036 During reset all stall outputs SHALL be 0, and IFID_flush=IDEX_flush=1, so the pipeline is cleared.
REQ-037 Reset asserted mid-MEM_WAIT or mid-REDIR_PEND SHALL abandon the pending redirect.

Structure
REQ-038 The state encoding, the timeout constant 255 and the counter width 16 SHALL reside in the shared pipeline package.
REQ-039 The block SHALL be a single module; the comparator logic MAY be a sub-module hazard_cmp (load-use match only).

Verification
REQ-040 Reset: rst_n=0 for 2 cycles -> IDEX_flush=IFID_flush=1, all counters 0, mem_timeout=0.
REQ-041 Load-use: MemRead_ex=1, rdAddr_ex=5, rs2Addr_id=5, rs2Used_id=1 -> one cycle of PC_stall=IFID_stall=IDEX_flush=1; stall_cnt=1.
REQ-042 Load-use, x0 case: the same stimulus with rdAddr_ex=0 -> no stall, no flush.
REQ-043 Redirect during wait: dmem_req=1, dmem_ready=0 for 3 cycles, Redirect_ex=1 in cycle 2 -> 3 cycles of full stall, then one REDIR_PEND cycle with both flushes, then RUN; stall_cnt=3, flush_cnt=1.
REQ-044 Timeout: dmem_ready=0 for 260 cycles -> mem_timeout=1 from cycle 255, stalls held throughout; reset clears the flag.
REQ-045 Saturation: 70000 consecutive load-use stalls -> stall_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller:
// the FSM state encoding, the memory-wait timeout and the event-counter width.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_REDIR_PEND = 2'd2
    } state_e;

    localparam int               CNT_W        = 16;
    localparam int               WAIT_W       = 8;
    localparam logic [WAIT_W-1:0] WAIT_TIMEOUT = 8'd255;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags an ID-stage read of the register a load in EX is writing.
// Register x0 is hardwired to zero, so it can never be the source of a hazard.
module hazard_cmp (
    input  logic       mem_read_i,
    input  logic [4:0] rd_addr_i,
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = rs1_used_i && (rs1_addr_i == rd_addr_i);
    assign rs2_hit    = rs2_used_i && (rs2_addr_i == rd_addr_i);
    assign load_use_o = mem_read_i && (rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and data-memory wait stalls,
// with a deferred redirect when a branch resolves while memory is stalling the pipe.
//
// state         | meaning
// ST_RUN        | normal flow; load-use and redirect handled directly
// ST_MEM_WAIT   | data memory busy; whole pipe frozen, redirect deferred into pend_q
// ST_REDIR_PEND | one-cycle flush of IF/ID and ID/EX for the deferred redirect
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_ex,
    input  logic [4:0]       rdAddr_ex,
    input  logic [4:0]       rs1Addr_id,
    input  logic [4:0]       rs2Addr_id,
    input  logic             rs1Used_id,
    input  logic             rs2Used_id,
    input  logic             Redirect_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PC_stall,
    output logic             IFID_stall,
    output logic             IDEX_stall,
    output logic             EXMEM_stall,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e            state_q;
    logic              pend_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              mem_timeout_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic load_use;
    logic mem_wait;

    hazard_cmp u_cmp (
        .mem_read_i (MemRead_ex),
        .rd_addr_i  (rdAddr_ex),
        .rs1_addr_i (rs1Addr_id),
        .rs2_addr_i (rs2Addr_id),
        .rs1_used_i (rs1Used_id),
        .rs2_used_i (rs2Used_id),
        .load_use_o (load_use)
    );

    assign mem_wait = dmem_req && !dmem_ready;

    // Hazard responses act in the same cycle, so they are decoded combinationally.
    always_comb begin
        PC_stall    = 1'b0;
        IFID_stall  = 1'b0;
        IDEX_stall  = 1'b0;
        EXMEM_stall = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        if (!rst_n) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (mem_wait) begin
            PC_stall    = 1'b1;
            IFID_stall  = 1'b1;
            IDEX_stall  = 1'b1;
            EXMEM_stall = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (Redirect_ex) begin
                        IFID_flush = 1'b1;
                        IDEX_flush = 1'b1;
                    end else if (load_use) begin
                        PC_stall   = 1'b1;
                        IFID_stall = 1'b1;
                        IDEX_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    // Exit cycle: a redirect here is deferred, otherwise load-use still applies.
                    if (!Redirect_ex && load_use) begin
                        PC_stall   = 1'b1;
                        IFID_stall = 1'b1;
                        IDEX_flush = 1'b1;
                    end
                end
                ST_REDIR_PEND: begin
                    IFID_flush = 1'b1;
                    IDEX_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pend_q        <= 1'b0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= sat_inc(stall_cnt_q, PC_stall);
            flush_cnt_q <= sat_inc(flush_cnt_q, IDEX_flush);
            case (state_q)
                ST_RUN: begin
                    if (mem_wait) begin
                        state_q    <= ST_MEM_WAIT;
                        wait_cnt_q <= '0;
                        pend_q     <= Redirect_ex;
                    end
                end
                ST_MEM_WAIT: begin
                    if (wait_cnt_q != WAIT_TIMEOUT) begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                    // Flag goes up as the count lands on the timeout value; the stall is kept.
                    if (wait_cnt_q == WAIT_TIMEOUT - WAIT_W'(1)) begin
                        mem_timeout_q <= 1'b1;
                    end
                    if (Redirect_ex) begin
                        pend_q <= 1'b1;
                    end
                    if (!mem_wait) begin
                        state_q <= (pend_q || Redirect_ex) ? ST_REDIR_PEND : ST_RUN;
                    end
                end
                ST_REDIR_PEND: begin
                    // A new memory wait here postpones the flush; pend_q stays set.
                    if (mem_wait) begin
                        state_q    <= ST_MEM_WAIT;
                        wait_cnt_q <= '0;
                    end else begin
                        pend_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs driven on the falling edge, outputs checked 1 ns later.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_ex;
    logic [4:0]  rdAddr_ex;
    logic [4:0]  rs1Addr_id;
    logic [4:0]  rs2Addr_id;
    logic        rs1Used_id;
    logic        rs2Used_id;
    logic        Redirect_ex;
    logic        dmem_req;
    logic        dmem_ready;
    logic        PC_stall;
    logic        IFID_stall;
    logic        IDEX_stall;
    logic        EXMEM_stall;
    logic        IFID_flush;
    logic        IDEX_flush;
    logic        mem_timeout;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead_ex  (MemRead_ex),
        .rdAddr_ex   (rdAddr_ex),
        .rs1Addr_id  (rs1Addr_id),
        .rs2Addr_id  (rs2Addr_id),
        .rs1Used_id  (rs1Used_id),
        .rs2Used_id  (rs2Used_id),
        .Redirect_ex (Redirect_ex),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .PC_stall    (PC_stall),
        .IFID_stall  (IFID_stall),
        .IDEX_stall  (IDEX_stall),
        .EXMEM_stall (EXMEM_stall),
        .IFID_flush  (IFID_flush),
        .IDEX_flush  (IDEX_flush),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Packs {PC, IFID, IDEX, EXMEM stall, IFID flush, IDEX flush} into one 6-bit word.
    function automatic logic [31:0] haz();
        return {26'd0, PC_stall, IFID_stall, IDEX_stall, EXMEM_stall, IFID_flush, IDEX_flush};
    endfunction

    localparam logic [31:0] H_NONE  = 32'b000000;
    localparam logic [31:0] H_ALL   = 32'b111100;
    localparam logic [31:0] H_FLUSH = 32'b000011;
    localparam logic [31:0] H_LU    = 32'b110001;

    task automatic idle();
        MemRead_ex  = 1'b0;
        rdAddr_ex   = 5'd0;
        rs1Addr_id  = 5'd0;
        rs2Addr_id  = 5'd0;
        rs1Used_id  = 1'b0;
        rs2Used_id  = 1'b0;
        Redirect_ex = 1'b0;
        dmem_req    = 1'b0;
        dmem_ready  = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        MemRead_ex = 1'b1;
        rdAddr_ex  = rd;
        rs1Addr_id = rs1;
        rs1Used_id = u1;
        rs2Addr_id = rs2;
        rs2Used_id = u2;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_hazard", haz(), H_FLUSH);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_timeout", mem_timeout, 0);

        // Load-use through rs2, one cycle, then the load has moved on.
        rst_n = 1'b1;
        next();
        check("run_idle", haz(), H_NONE);
        set_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        check("lu_rs2", haz(), H_LU);
        next();
        idle();
        #1;
        check("lu_after", haz(), H_NONE);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_flush_cnt", flush_cnt, 1);

        set_lu(5'd7, 5'd7, 1'b1, 5'd3, 1'b1);
        #1;
        check("lu_rs1", haz(), H_LU);
        set_lu(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        #1;
        check("lu_rs1_unused", haz(), H_NONE);
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        check("lu_x0", haz(), H_NONE);
        MemRead_ex = 1'b0;
        rdAddr_ex  = 5'd9;
        rs1Addr_id = 5'd9;
        #1;
        check("no_load", haz(), H_NONE);

        idle();
        Redirect_ex = 1'b1;
        #1;
        check("redirect", haz(), H_FLUSH);
        set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        #1;
        check("redirect_over_lu", haz(), H_FLUSH);

        // Redirect arriving during a 3-cycle memory wait.
        do_reset();
        dmem_req = 1'b1;
        #1;
        check("mw_c1", haz(), H_ALL);
        next();
        Redirect_ex = 1'b1;
        #1;
        check("mw_c2_redir", haz(), H_ALL);
        next();
        Redirect_ex = 1'b0;
        #1;
        check("mw_c3", haz(), H_ALL);
        next();
        dmem_ready = 1'b1;
        #1;
        check("mw_exit", haz(), H_NONE);
        next();
        idle();
        Redirect_ex = 1'b1;
        set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
        #1;
        check("redir_pend", haz(), H_FLUSH);
        next();
        idle();
        #1;
        check("back_run", haz(), H_NONE);
        check("mw_stall_cnt", stall_cnt, 3);
        check("mw_flush_cnt", flush_cnt, 1);

        // Redirect together with the start of a wait is deferred too.
        dmem_req    = 1'b1;
        Redirect_ex = 1'b1;
        #1;
        check("mw_redir_entry", haz(), H_ALL);
        next();
        Redirect_ex = 1'b0;
        dmem_ready  = 1'b1;
        #1;
        check("mw_entry_exit", haz(), H_NONE);
        next();
        idle();
        #1;
        check("redir_pend2", haz(), H_FLUSH);
        next();
        check("back_run2", haz(), H_NONE);

        // Wait with no redirect returns straight to RUN.
        dmem_req = 1'b1;
        next();
        dmem_req = 1'b0;
        #1;
        check("plain_exit", haz(), H_NONE);
        next();
        check("plain_no_flush", haz(), H_NONE);

        // Timeout: flag appears after the 256th wait edge and the stall persists.
        do_reset();
        dmem_req = 1'b1;
        repeat (255) @(posedge clk);
        @(negedge clk);
        #1;
        check("to_before", mem_timeout, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("to_set", mem_timeout, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        check("to_held", mem_timeout, 1);
        check("to_stall", haz(), H_ALL);
        check("to_stall_cnt", stall_cnt, 260);
        dmem_req = 1'b0;
        next();
        check("to_sticky", mem_timeout, 1);
        do_reset();
        #1;
        check("to_cleared", mem_timeout, 0);

        // Counter saturation under back-to-back load-use stalls.
        set_lu(5'd12, 5'd0, 1'b0, 5'd12, 1'b1);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        #1;
        check("sat_fffe", stall_cnt, 16'hFFFE);
        repeat (70000 - 65534) @(posedge clk);
        @(negedge clk);
        #1;
        check("sat_stall", stall_cnt, 16'hFFFF);
        check("sat_flush", flush_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
